npc_unit: RTL and testbench
===========================

Name: npc_unit

Overview:
- Next-PC stage directly upstream of the PC register. Produces the value that register loads on each clock.
- Implements MIPS branch/jump target arithmetic and the one-instruction branch delay slot, tracked by a two-state sequencer with a pending-target register.
- Also supplies the link address for jal and fault flags for illegal control flow.

Parameters:
- RESET_PC, 32'h0000_3000, address driven on npc while reset is high; must match the PC register reset value.

Ports:
- clk  in  1  clock, all state updates on posedge.
- reset  in  1  synchronous, active-high.
- pc  in  32  current PC from the PC register (address of the instruction in decode).
- stall  in  1  hold the current instruction; no state change, npc = pc.
- br_op  in  3  control class of the instruction at pc: NONE / BCOND / J / JAL / JR (codes in package).
- br_cond  in  1  branch condition result for BCOND (1 = taken).
- imm16  in  16  branch offset field.
- j_index  in  26  jump index field.
- jr_target  in  32  rs register value for JR.
- npc  out  32  next PC, to the PC register's load input.
- link_addr  out  32  pc + 8, written to $31 by JAL.
- in_slot  out  1  instruction at pc is a delay-slot instruction.
- slot_ctrl_err  out  1  sticky: a control instruction appeared in a delay slot.
- align_err  out  1  sticky: a JR target had nonzero bits [1:0].

Behaviour:
- States:
  - SEQ: no redirect pending.
  - SLOT: pc holds the delay-slot instruction; a target is pending in tgt_q.
- Reset, synchronous: state=SEQ, tgt_q=0, slot_ctrl_err=0, align_err=0. While reset is high, npc=RESET_PC and in_slot=0.
- npc, link_addr and in_slot are combinational from pc, state and inputs. There is no added latency: the redirect lands on the PC register's next clock.
- Target arithmetic, all 32-bit modulo 2^32 (wrap from 0xFFFFFFFC to 0x0 is legal):
  - BCOND: pc + 4 + (sign_extend(imm16) << 2).
  - J/JAL: {pc_plus4[31:28], j_index, 2'b00}.
  - JR: {jr_target[31:2], 2'b00}. Low bits are forced to 0; align_err is set if jr_target[1:0] != 0.
- SEQ, stall=0:
  - br_op=NONE, or BCOND with br_cond=0: npc = pc+4; stay in SEQ.
  - BCOND with br_cond=1, or J, JAL, JR: npc = pc+4 (the delay slot); tgt_q <= target; go to SLOT.
- SLOT, stall=0:
  - npc = tgt_q; go to SEQ; in_slot=1.
  - If br_op != NONE: the instruction's control effect is ignored, slot_ctrl_err <= 1, and no new target is latched.
- stall=1, any state: npc = pc; state, tgt_q and error flags hold.
  - Exception: the error flags are still evaluated and set for the current instruction only when stall=0.
- link_addr = pc + 8 at all times. It is meaningful only for JAL.
- Sticky flags clear only on reset.
- Reset asserted while in SLOT: the pending target is discarded and fetch restarts at RESET_PC.
- Illegal br_op codes (101–111) are treated as NONE.

Decomposition:
- Shared package (mips_pkg):
  - br_op localparams: BR_NONE=3'b000, BR_COND=3'b001, BR_J=3'b010, BR_JAL=3'b011, BR_JR=3'b100.
  - RESET_PC constant 32'h0000_3000, shared with the PC register.
  - State encoding: SEQ=1'b0, SLOT=1'b1.
- One combinational sub-module, npc_target: computes the branch/jump target and the alignment check from pc, br_op, imm16, j_index and jr_target.
- npc_unit itself holds the state, tgt_q, the sticky flags and the npc mux.

Test Plan:
- Reset and sequential flow: reset high → npc=0x3000. Release, then pc=0x3000 with br_op=NONE → npc=0x3004, in_slot=0, link_addr=0x3008.
- Taken branch with delay slot: pc=0x3010, BCOND, cond=1, imm16=0xFFFC → npc=0x3014. Next cycle pc=0x3014 → npc=0x3004, in_slot=1, then state returns to SEQ.
- Not-taken branch and jal: BCOND with cond=0 at 0x3020 → npc=0x3024 and state stays SEQ. JAL at 0x3030 with j_index=0x0000C40 → npc=0x3034, then 0x3100; link_addr=0x3038.
- JR misaligned: jr_target=0x0000_3102 at pc 0x3040 → npc=0x3044, then 0x3100; align_err=1 and it stays set until reset.
- Stall in slot: taken J, then stall=1 for 3 cycles while pc=slot addr → npc=pc and in_slot=1 throughout; after stall drops, npc=target.
- Control in slot and reset mid-slot: J in the slot of a taken BCOND → the first target is used and slot_ctrl_err=1. Separately, assert reset while in SLOT → npc=0x3000, in_slot=0, flags cleared.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS control-flow definitions: branch-op codes, reset PC, next-PC sequencer states.
package mips_pkg;

    localparam logic [2:0] BR_NONE = 3'b000;
    localparam logic [2:0] BR_COND = 3'b001;
    localparam logic [2:0] BR_J    = 3'b010;
    localparam logic [2:0] BR_JAL  = 3'b011;
    localparam logic [2:0] BR_JR   = 3'b100;

    localparam logic [31:0] RESET_PC = 32'h0000_3000;

    typedef enum logic {
        SEQ  = 1'b0,
        SLOT = 1'b1
    } npc_state_e;

    // Codes 101-111 are not control instructions and behave like BR_NONE.
    function automatic logic is_ctrl_op(input logic [2:0] op);
        return (op == BR_COND) || (op == BR_J) || (op == BR_JAL) || (op == BR_JR);
    endfunction

endpackage

// File: rtl/npc_unit_target.sv
// Combinational branch/jump target arithmetic and JR alignment check for the instruction at pc.
module npc_target
    import mips_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [2:0]  br_op,
    input  logic [15:0] imm16,
    input  logic [25:0] j_index,
    input  logic [31:0] jr_target,
    output logic [31:0] target,
    output logic        is_ctrl,
    output logic        jr_misaligned
);

    logic [31:0] pc_plus4;
    logic [31:0] br_offset;

    assign pc_plus4  = pc + 32'd4;
    assign br_offset = {{14{imm16[15]}}, imm16, 2'b00};
    assign is_ctrl   = is_ctrl_op(br_op);

    always_comb begin
        target        = pc_plus4;
        jr_misaligned = 1'b0;
        case (br_op)
            BR_COND:       target = pc_plus4 + br_offset;
            BR_J, BR_JAL:  target = {pc_plus4[31:28], j_index, 2'b00};
            BR_JR: begin
                target        = {jr_target[31:2], 2'b00};
                jr_misaligned = (jr_target[1:0] != 2'b00);
            end
            default:       target = pc_plus4;
        endcase
    end

endmodule

// File: rtl/npc_unit.sv
// Next-PC stage: computes the PC register's load value, handling the single branch delay slot
// with a SEQ/SLOT sequencer and a pending-target register.
module npc_unit #(
    parameter logic [31:0] RESET_PC = mips_pkg::RESET_PC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    input  logic        stall,
    input  logic [2:0]  br_op,
    input  logic        br_cond,
    input  logic [15:0] imm16,
    input  logic [25:0] j_index,
    input  logic [31:0] jr_target,
    output logic [31:0] npc,
    output logic [31:0] link_addr,
    output logic        in_slot,
    output logic        slot_ctrl_err,
    output logic        align_err
);
    import mips_pkg::*;

    npc_state_e  state_q, state_d;
    logic [31:0] tgt_q, tgt_d;
    logic        slot_err_q, slot_err_d;
    logic        align_err_q, align_err_d;

    logic [31:0] target;
    logic        is_ctrl;
    logic        jr_misaligned;
    logic        taken;

    npc_target u_target (
        .pc            (pc),
        .br_op         (br_op),
        .imm16         (imm16),
        .j_index       (j_index),
        .jr_target     (jr_target),
        .target        (target),
        .is_ctrl       (is_ctrl),
        .jr_misaligned (jr_misaligned)
    );

    assign taken = is_ctrl && ((br_op != BR_COND) || br_cond);

    always_ff @(posedge clk) begin
        state_q     <= state_d;
        tgt_q       <= tgt_d;
        slot_err_q  <= slot_err_d;
        align_err_q <= align_err_d;
    end

    always_comb begin
        state_d     = state_q;
        tgt_d       = tgt_q;
        slot_err_d  = slot_err_q;
        align_err_d = align_err_q;
        if (reset) begin
            state_d     = SEQ;
            tgt_d       = '0;
            slot_err_d  = 1'b0;
            align_err_d = 1'b0;
        end else if (!stall) begin
            case (state_q)
                SLOT: begin
                    // Slot instruction's own control effect is dropped, including its JR alignment.
                    state_d = SEQ;
                    if (is_ctrl) slot_err_d = 1'b1;
                end
                default: begin
                    if (taken) begin
                        state_d = SLOT;
                        tgt_d   = target;
                        if (br_op == BR_JR && jr_misaligned) align_err_d = 1'b1;
                    end
                end
            endcase
        end
    end

    always_comb begin
        npc     = pc + 32'd4;
        in_slot = (state_q == SLOT);
        if (reset) begin
            npc     = RESET_PC;
            in_slot = 1'b0;
        end else if (stall) begin
            npc = pc;
        end else if (state_q == SLOT) begin
            npc = tgt_q;
        end
    end

    assign link_addr     = pc + 32'd8;
    assign slot_ctrl_err = slot_err_q;
    assign align_err     = align_err_q;

endmodule

// File: tb/tb_npc_unit.sv
// Self-checking bench for npc_unit: directed scenarios followed by randomized control flow
// checked against a transaction-level model of the delay-slot behaviour.
module tb_npc_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc;
    logic        stall;
    logic [2:0]  br_op;
    logic        br_cond;
    logic [15:0] imm16;
    logic [25:0] j_index;
    logic [31:0] jr_target;
    logic [31:0] npc, link_addr;
    logic        in_slot, slot_ctrl_err, align_err;

    int n_chk = 0;
    int n_err = 0;

    // Reference model state: a pending redirect and the two sticky flags.
    bit          m_pending;
    logic [31:0] m_tgt;
    bit          m_serr, m_aerr;
    logic [31:0] m_last_npc;

    always #5 clk = ~clk;

    npc_unit dut (
        .clk           (clk),
        .reset         (reset),
        .pc            (pc),
        .stall         (stall),
        .br_op         (br_op),
        .br_cond       (br_cond),
        .imm16         (imm16),
        .j_index       (j_index),
        .jr_target     (jr_target),
        .npc           (npc),
        .link_addr     (link_addr),
        .in_slot       (in_slot),
        .slot_ctrl_err (slot_ctrl_err),
        .align_err     (align_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_target(input logic [2:0] op, input logic [31:0] p,
                                                 input logic [15:0] imm, input logic [25:0] ji,
                                                 input logic [31:0] jr);
        int signed off;
        off = $signed(imm);
        case (op)
            3'd1:       return p + 32'd4 + 32'(off * 4);
            3'd2, 3'd3: return ((p + 32'd4) & 32'hF000_0000) | (32'(ji) * 32'd4);
            3'd4:       return jr & 32'hFFFF_FFFC;
            default:    return p + 32'd4;
        endcase
    endfunction

    // Apply one cycle: drive inputs, check outputs mid-cycle, advance the model at the edge.
    task automatic step(input logic rst, input logic [31:0] p, input logic stl, input logic [2:0] op,
                        input logic cond, input logic [15:0] imm, input logic [25:0] ji,
                        input logic [31:0] jr);
        logic [31:0] e_npc;
        bit          e_slot, ctrl;
        reset = rst; pc = p; stall = stl; br_op = op; br_cond = cond;
        imm16 = imm; j_index = ji; jr_target = jr;
        ctrl = (op >= 3'd1 && op <= 3'd4);
        if (rst)            begin e_npc = 32'h0000_3000; e_slot = 0; end
        else if (stl)       begin e_npc = p;             e_slot = m_pending; end
        else if (m_pending) begin e_npc = m_tgt;         e_slot = 1; end
        else                begin e_npc = p + 32'd4;     e_slot = 0; end
        @(negedge clk);
        chk("npc", npc, e_npc);
        chk("in_slot", 32'(in_slot), 32'(e_slot));
        chk("link_addr", link_addr, p + 32'd8);
        chk("slot_ctrl_err", 32'(slot_ctrl_err), 32'(m_serr));
        chk("align_err", 32'(align_err), 32'(m_aerr));
        m_last_npc = e_npc;
        @(posedge clk);
        if (rst) begin
            m_pending = 0; m_tgt = '0; m_serr = 0; m_aerr = 0;
        end else if (!stl) begin
            if (m_pending) begin
                m_pending = 0;
                if (ctrl) m_serr = 1;
            end else if (ctrl && (op != 3'd1 || cond)) begin
                m_pending = 1;
                m_tgt = model_target(op, p, imm, ji, jr);
                if (op == 3'd4 && jr[1:0] != 2'b00) m_aerr = 1;
            end
        end
        #1;
    endtask

    task automatic seq(input logic [31:0] p);
        step(0, p, 0, 3'd0, 0, 16'h0, 26'h0, 32'h0);
    endtask

    initial begin
        m_pending = 0; m_tgt = '0; m_serr = 0; m_aerr = 0; m_last_npc = 32'h3000;
        step(1, 32'h0, 0, 3'd0, 0, 16'h0, 26'h0, 32'h0);
        step(1, 32'h0, 0, 3'd0, 0, 16'h0, 26'h0, 32'h0);
        // Sequential fetch
        seq(32'h3000);
        // Taken branch back to 0x3004, then its slot
        step(0, 32'h3010, 0, 3'd1, 1, 16'hFFFC, 26'h0, 32'h0);
        chk("bcond_slot_npc", m_last_npc, 32'h3014);
        seq(32'h3014);
        chk("bcond_target", m_last_npc, 32'h3004);
        seq(32'h3004);
        // Not-taken branch
        step(0, 32'h3020, 0, 3'd1, 0, 16'h0010, 26'h0, 32'h0);
        seq(32'h3024);
        // JAL
        step(0, 32'h3030, 0, 3'd3, 0, 16'h0, 26'h0000C40, 32'h0);
        seq(32'h3034);
        chk("jal_target", m_last_npc, 32'h3100);
        // Misaligned JR
        step(0, 32'h3040, 0, 3'd4, 0, 16'h0, 26'h0, 32'h0000_3102);
        seq(32'h3044);
        chk("jr_target", m_last_npc, 32'h3100);
        seq(32'h3100);
        chk("align_err_sticky", 32'(align_err), 32'd1);
        // Stall in the slot of a J
        step(0, 32'h3100, 0, 3'd2, 0, 16'h0, 26'h0000D00, 32'h0);
        for (int i = 0; i < 3; i++) step(0, 32'h3104, 1, 3'd0, 0, 16'h0, 26'h0, 32'h0);
        seq(32'h3104);
        chk("j_after_stall", m_last_npc, 32'h3400);
        // J in the slot of a taken branch: first target wins
        step(0, 32'h3400, 0, 3'd1, 1, 16'h0010, 26'h0, 32'h0);
        step(0, 32'h3404, 0, 3'd2, 0, 16'h0, 26'h0000999, 32'h0);
        seq(32'h3444);
        chk("slot_ctrl_err_set", 32'(slot_ctrl_err), 32'd1);
        // Reset while in SLOT
        step(0, 32'h3448, 0, 3'd2, 0, 16'h0, 26'h0000123, 32'h0);
        step(1, 32'h344C, 0, 3'd0, 0, 16'h0, 26'h0, 32'h0);
        seq(32'h3000);
        chk("flags_cleared", 32'({slot_ctrl_err, align_err, in_slot}), 32'd0);
        // Wrap-around branch target
        step(0, 32'hFFFF_FFF8, 0, 3'd1, 1, 16'h0001, 26'h0, 32'h0);
        seq(32'hFFFF_FFFC);
        chk("wrap_target", m_last_npc, 32'h0000_0000);
        // Randomized flow: mostly follow npc, with random ops, stalls, and occasional resets
        for (int i = 0; i < 2000; i++) begin
            logic [31:0] p;
            logic [2:0]  op;
            p  = ($urandom_range(0, 9) == 0) ? ($urandom & 32'hFFFF_FFFC) : m_last_npc;
            op = 3'($urandom_range(0, 7));
            step(($urandom_range(0, 99) == 0), p, ($urandom_range(0, 5) == 0), op,
                 1'($urandom), 16'($urandom), 26'($urandom), $urandom);
        end
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
